// File: rtl/usb_buffer_pkg.sv
// -----------------------------------------------------------------------------
// usb_buffer_pkg
// Shared sizing constants and the push/pop source enumeration for the USB
// endpoint data buffer.
//   DEPTH  : number of byte entries (power of two)
//   ADDR_W : pointer width, log2(DEPTH)
//   CNT_W  : occupancy width, wide enough to hold DEPTH itself
//   src_e  : which side of the buffer a push or pop comes from
// -----------------------------------------------------------------------------
package usb_buffer_pkg;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;
    localparam int CNT_W  = 7;

    typedef enum logic {
        SRC_AHB = 1'b0,
        SRC_USB = 1'b1
    } src_e;

endpackage : usb_buffer_pkg

// File: rtl/buffer_ram.sv
// -----------------------------------------------------------------------------
// buffer_ram
// DEPTH x 8 byte storage for the endpoint buffer. One synchronous write port
// and one asynchronous read port, so the head byte is available in the same
// cycle the read address changes. The array has no reset.
// Ports:
//   clk    in   system clock
//   we     in   write enable, writes wdata at waddr on the rising edge
//   waddr  in   write address
//   wdata  in   write byte
//   raddr  in   read address
//   rdata  out  byte stored at raddr (combinational)
// -----------------------------------------------------------------------------
module buffer_ram
    import usb_buffer_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [7:0]        rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read keeps the buffer show-ahead.
    assign rdata = mem[raddr];

endmodule : buffer_ram

// File: rtl/data_buffer.sv
// -----------------------------------------------------------------------------
// data_buffer
// 64-byte endpoint FIFO shared by the AHB-lite slave register block and the
// USB RX/TX packet engines. Show-ahead: the head byte is presented
// combinationally on rx_data and tx_packet_data, and a pop strobe consumes it
// at the next rising edge.
// Ports:
//   clk                   in   system clock
//   n_rst                 in   asynchronous active-low reset
//   clear                 in   synchronous flush, wins over push/pop
//   store_tx_data/tx_data in   AHB-side push (higher push priority)
//   get_rx_data           in   AHB-side pop (higher pop priority)
//   store_rx_packet_data/
//   rx_packet_data        in   USB RX-side push
//   get_tx_packet_data    in   USB TX-side pop
//   rx_data               out  head byte, 8'h00 when empty
//   tx_packet_data        out  same head byte for the USB TX engine
//   buffer_occupancy      out  bytes held, 0..DEPTH
//   overflow/underflow    out  sticky error flags, only when the macro
//                              BUFFER_ERR_FLAGS_EN is defined
// -----------------------------------------------------------------------------
module data_buffer
    import usb_buffer_pkg::*;
(
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clear,
    input  logic             store_tx_data,
    input  logic [7:0]       tx_data,
    input  logic             get_rx_data,
    input  logic             store_rx_packet_data,
    input  logic [7:0]       rx_packet_data,
    input  logic             get_tx_packet_data,
    output logic [7:0]       rx_data,
    output logic [7:0]       tx_packet_data,
`ifdef BUFFER_ERR_FLAGS_EN
    output logic             overflow,
    output logic             underflow,
`endif
    output logic [CNT_W-1:0] buffer_occupancy
);

    logic [ADDR_W-1:0] wptr_reg;
    logic [ADDR_W-1:0] rptr_reg;
    logic [CNT_W-1:0]  occ_reg;

    logic       push_req;
    logic       pop_req;
    src_e       push_src;
    logic [7:0] push_byte;
    logic       empty;
    logic       full;
    logic       push_ok;
    logic       pop_ok;
    logic [7:0] ram_rdata;

    // The AHB side wins push arbitration; the USB RX push is dropped.
    assign push_req  = store_tx_data | store_rx_packet_data;
    assign push_src  = store_tx_data ? SRC_AHB : SRC_USB;
    assign push_byte = (push_src == SRC_AHB) ? tx_data : rx_packet_data;

    // Only one pop per cycle regardless of how many strobes are high.
    assign pop_req = get_rx_data | get_tx_packet_data;

    assign empty = (occ_reg == '0);
    assign full  = (occ_reg == CNT_W'(DEPTH));

    // Full blocks a push even if a pop frees a slot in the same cycle;
    // empty blocks a pop even if a push lands in the same cycle.
    assign push_ok = push_req & ~full  & ~clear;
    assign pop_ok  = pop_req  & ~empty & ~clear;

    buffer_ram u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wptr_reg),
        .wdata (push_byte),
        .raddr (rptr_reg),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
            occ_reg  <= '0;
        end else if (clear) begin
            wptr_reg <= '0;
            rptr_reg <= '0;
            occ_reg  <= '0;
        end else begin
            if (push_ok) begin
                wptr_reg <= wptr_reg + ADDR_W'(1);
            end
            if (pop_ok) begin
                rptr_reg <= rptr_reg + ADDR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                occ_reg <= occ_reg + CNT_W'(1);
            end else if (pop_ok && !push_ok) begin
                occ_reg <= occ_reg - CNT_W'(1);
            end
        end
    end

    // Storage is not reset, so mask the head while empty.
    assign rx_data          = empty ? 8'h00 : ram_rdata;
    assign tx_packet_data   = rx_data;
    assign buffer_occupancy = occ_reg;

`ifdef BUFFER_ERR_FLAGS_EN
    logic overflow_reg;
    logic underflow_reg;
    logic push_dropped;
    logic pop_on_empty;

    // A push is lost when the buffer is full or when it loses arbitration.
    assign push_dropped = (push_req & full) | (store_tx_data & store_rx_packet_data);
    assign pop_on_empty = pop_req & empty;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else if (clear) begin
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            if (push_dropped) begin
                overflow_reg <= 1'b1;
            end
            if (pop_on_empty) begin
                underflow_reg <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;
`endif

endmodule : data_buffer

// File: tb/tb_data_buffer.sv
// -----------------------------------------------------------------------------
// tb_data_buffer
// Directed self-checking bench for data_buffer. Inputs change 1 ns after the
// rising edge and outputs are sampled at the same point, away from the edge.
// Flag checks are included when BUFFER_ERR_FLAGS_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_data_buffer;
    import usb_buffer_pkg::*;

    logic             clk;
    logic             n_rst;
    logic             clear;
    logic             store_tx_data;
    logic [7:0]       tx_data;
    logic             get_rx_data;
    logic             store_rx_packet_data;
    logic [7:0]       rx_packet_data;
    logic             get_tx_packet_data;
    logic [7:0]       rx_data;
    logic [7:0]       tx_packet_data;
    logic [CNT_W-1:0] buffer_occupancy;
`ifdef BUFFER_ERR_FLAGS_EN
    logic             overflow;
    logic             underflow;
`endif

    int checks_total;
    int checks_passed;

    data_buffer dut (
        .clk                  (clk),
        .n_rst                (n_rst),
        .clear                (clear),
        .store_tx_data        (store_tx_data),
        .tx_data              (tx_data),
        .get_rx_data          (get_rx_data),
        .store_rx_packet_data (store_rx_packet_data),
        .rx_packet_data       (rx_packet_data),
        .get_tx_packet_data   (get_tx_packet_data),
        .rx_data              (rx_data),
        .tx_packet_data       (tx_packet_data),
`ifdef BUFFER_ERR_FLAGS_EN
        .overflow             (overflow),
        .underflow            (underflow),
`endif
        .buffer_occupancy     (buffer_occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
            $display("check %-22s observed=%0h expected=%0h ok", tag, observed, expected);
        end else begin
            $display("FAIL %-22s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic idle_inputs();
        clear                = 1'b0;
        store_tx_data        = 1'b0;
        tx_data              = 8'h00;
        get_rx_data          = 1'b0;
        store_rx_packet_data = 1'b0;
        rx_packet_data       = 8'h00;
        get_tx_packet_data   = 1'b0;
    endtask

    // Advance one clock, leaving the bench 1 ns past the rising edge with all
    // strobes released.
    task automatic step();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic push_tx(input logic [7:0] b);
        store_tx_data = 1'b1;
        tx_data       = b;
        step();
    endtask

    task automatic push_rx(input logic [7:0] b);
        store_rx_packet_data = 1'b1;
        rx_packet_data       = b;
        step();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        idle_inputs();
        n_rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_occ", 32'(buffer_occupancy), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'h00);
        check("reset_tx_pkt", 32'(tx_packet_data), 32'h00);
`ifdef BUFFER_ERR_FLAGS_EN
        check("reset_overflow", 32'(overflow), 32'd0);
        check("reset_underflow", 32'(underflow), 32'd0);
`endif
        n_rst = 1'b1;
        step();

        // 1: single AHB push then AHB pop.
        push_tx(8'hA5);
        check("t1_occ_after_push", 32'(buffer_occupancy), 32'd1);
        check("t1_rx_data", 32'(rx_data), 32'hA5);
        check("t1_tx_pkt", 32'(tx_packet_data), 32'hA5);
        get_rx_data = 1'b1;
        #1;
        check("t1_head_at_pop", 32'(rx_data), 32'hA5);
        step();
        check("t1_occ_after_pop", 32'(buffer_occupancy), 32'd0);
        check("t1_rx_data_empty", 32'(rx_data), 32'h00);

        // 2: fill via RX side (pointers start at 1, so the fill wraps).
        for (int i = 0; i < 64; i++) push_rx(8'(i));
        check("t2_occ_full", 32'(buffer_occupancy), 32'd64);
        check("t2_head", 32'(rx_data), 32'h00);
        push_rx(8'h99);
        check("t2_occ_after_drop", 32'(buffer_occupancy), 32'd64);
        check("t2_head_after_drop", 32'(rx_data), 32'h00);
`ifdef BUFFER_ERR_FLAGS_EN
        check("t2_overflow", 32'(overflow), 32'd1);
`endif

        // 3: drain via TX side in order.
        for (int i = 0; i < 64; i++) begin
            check($sformatf("t3_pop_%0d", i), 32'(tx_packet_data), 32'(i));
            get_tx_packet_data = 1'b1;
            step();
        end
        check("t3_occ_drained", 32'(buffer_occupancy), 32'd0);
        check("t3_head_drained", 32'(tx_packet_data), 32'h00);
        push_tx(8'hB0);
        push_tx(8'hB1);
        push_tx(8'hB2);
        check("t3_refill_occ", 32'(buffer_occupancy), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t3_refill_%0d", i), 32'(rx_data), 32'(8'hB0 + 8'(i)));
            get_rx_data = 1'b1;
            step();
        end
        check("t3_refill_empty", 32'(buffer_occupancy), 32'd0);

        // Clear returns flags to zero.
        do_clear();
`ifdef BUFFER_ERR_FLAGS_EN
        check("clr_overflow", 32'(overflow), 32'd0);
`endif

        // 4: simultaneous push and pop.
        for (int i = 0; i < 10; i++) push_tx(8'h40 + 8'(i));
        check("t4_occ10", 32'(buffer_occupancy), 32'd10);
        check("t4_head", 32'(rx_data), 32'h40);
        store_tx_data = 1'b1;
        tx_data       = 8'h77;
        get_rx_data   = 1'b1;
        step();
        check("t4_occ_pushpop", 32'(buffer_occupancy), 32'd10);
        check("t4_head_adv", 32'(rx_data), 32'h41);
        do_clear();
        check("t4_cleared", 32'(buffer_occupancy), 32'd0);
        store_rx_packet_data = 1'b1;
        rx_packet_data       = 8'h55;
        get_tx_packet_data   = 1'b1;
        step();
        check("t4_empty_pushpop", 32'(buffer_occupancy), 32'd1);
        check("t4_empty_head", 32'(tx_packet_data), 32'h55);
`ifdef BUFFER_ERR_FLAGS_EN
        check("t4_underflow", 32'(underflow), 32'd1);
`endif

        // 5: push arbitration, then pop arbitration.
        do_clear();
        store_tx_data        = 1'b1;
        tx_data              = 8'h11;
        store_rx_packet_data = 1'b1;
        rx_packet_data       = 8'h22;
        step();
        check("t5_occ_arb", 32'(buffer_occupancy), 32'd1);
        check("t5_head_arb", 32'(rx_data), 32'h11);
`ifdef BUFFER_ERR_FLAGS_EN
        check("t5_overflow_arb", 32'(overflow), 32'd1);
`endif
        push_rx(8'h33);
        get_rx_data        = 1'b1;
        get_tx_packet_data = 1'b1;
        step();
        check("t5_occ_pop_arb", 32'(buffer_occupancy), 32'd1);
        check("t5_head_pop_arb", 32'(rx_data), 32'h33);

        // Full with push and pop together: push dropped, pop taken.
        do_clear();
        for (int i = 0; i < 64; i++) push_tx(8'h80 + 8'(i));
        store_tx_data = 1'b1;
        tx_data       = 8'hEE;
        get_rx_data   = 1'b1;
        step();
        check("full_pushpop_occ", 32'(buffer_occupancy), 32'd63);
        check("full_pushpop_head", 32'(rx_data), 32'h81);

        // 6: clear overrides a push, later pop on empty is ignored.
        do_clear();
        for (int i = 0; i < 20; i++) push_rx(8'(i) + 8'h10);
        check("t6_occ20", 32'(buffer_occupancy), 32'd20);
        clear         = 1'b1;
        store_tx_data = 1'b1;
        tx_data       = 8'hCC;
        step();
        check("t6_occ_cleared", 32'(buffer_occupancy), 32'd0);
        check("t6_head_cleared", 32'(rx_data), 32'h00);
`ifdef BUFFER_ERR_FLAGS_EN
        check("t6_underflow_pre", 32'(underflow), 32'd0);
`endif
        get_rx_data = 1'b1;
        step();
        check("t6_occ_pop_empty", 32'(buffer_occupancy), 32'd0);
`ifdef BUFFER_ERR_FLAGS_EN
        check("t6_underflow", 32'(underflow), 32'd1);
`endif
        push_tx(8'h5A);
        check("t6_after_ignored_pop", 32'(rx_data), 32'h5A);

        // Asynchronous reset mid-burst empties the buffer immediately.
        push_tx(8'h01);
        push_tx(8'h02);
        #2;
        n_rst = 1'b0;
        #1;
        check("rst_mid_occ", 32'(buffer_occupancy), 32'd0);
        check("rst_mid_head", 32'(rx_data), 32'h00);
        step();
        n_rst = 1'b1;
        step();
        push_tx(8'h3C);
        check("rst_after_occ", 32'(buffer_occupancy), 32'd1);
        check("rst_after_head", 32'(rx_data), 32'h3C);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule : tb_data_buffer
